// File: rtl/cache_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter_pkg
// Description : Shared types and helpers for the L1 cache / physical memory
//               arbiter. Holds the arbiter state encoding, the grant
//               encoding and the contention-resolution function.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_arbiter_pkg;

  // Arbiter states. DONE is a one-cycle gap after every response so the
  // served cache can drop its request before the next grant decision.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  // Which cache owns the memory port for the current transaction.
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

  // Pick the winner in IDLE. A lone requester always wins. Under contention
  // the cache that was not granted last wins, so grants alternate.
  function automatic arb_grant_t arb_pick(
    input logic       i_req,
    input logic       d_req,
    input arb_grant_t last_grant
  );
    arb_grant_t w_pick;
    if (i_req && d_req) begin
      w_pick = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (d_req) begin
      w_pick = GRANT_D;
    end else begin
      w_pick = GRANT_I;
    end
    return w_pick;
  endfunction

endpackage : cache_arbiter_pkg
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter
// Description : Shares one physical memory port between the instruction
//               cache (read-only) and the data cache (read/write). Latches
//               the granted request, runs one line transaction, and returns
//               the response only to the granted cache. Contention is
//               resolved by alternating grants. All outputs are registered.
// Revision    : 1.0 - initial release
//
// Ports
//   clk           in   clock, all state updates on the rising edge
//   reset         in   asynchronous active-high reset
//   i_read        in   icache line read request (held until i_resp)
//   i_address     in   icache line address
//   i_resp        out  one-cycle pulse, icache read complete
//   i_rdata       out  line returned to icache, valid with i_resp
//   d_read        in   dcache read request (held until d_resp)
//   d_write       in   dcache write request (held until d_resp)
//   d_address     in   dcache line address
//   d_wdata       in   dcache writeback line
//   d_resp        out  one-cycle pulse, dcache transaction complete
//   d_rdata       out  line returned to dcache, valid with d_resp
//   pmem_read     out  memory read command, held until pmem_resp
//   pmem_write    out  memory write command, held until pmem_resp
//   pmem_address  out  latched address of the granted request
//   pmem_wdata    out  latched write line
//   pmem_rdata    in   memory read line, valid with pmem_resp
//   pmem_resp     in   memory transaction complete
// ============================================================================
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,

  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  arb_state_t            r_state;
  arb_grant_t            r_last_grant;
  logic                  r_pmem_read;
  logic                  r_pmem_write;
  logic [ADDR_WIDTH-1:0] r_pmem_address;
  logic [LINE_WIDTH-1:0] r_pmem_wdata;
  logic                  r_i_resp;
  logic                  r_d_resp;
  logic [LINE_WIDTH-1:0] r_i_rdata;
  logic [LINE_WIDTH-1:0] r_d_rdata;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  arb_state_t w_state_next;
  arb_grant_t w_grant;
  logic       w_take;
  logic       w_d_req;

  // A simultaneous read and write from the dcache is treated as a write;
  // either bit alone is a valid request.
  assign w_d_req = d_read | d_write;

  always_comb begin
    w_state_next = r_state;
    w_grant      = r_last_grant;
    w_take       = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_read || w_d_req) begin
          w_take       = 1'b1;
          w_grant      = arb_pick(i_read, w_d_req, r_last_grant);
          w_state_next = (w_grant == GRANT_D) ? D_BUSY : I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_last_grant   <= GRANT_I;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
      r_i_resp       <= 1'b0;
      r_d_resp       <= 1'b0;
      r_i_rdata      <= '0;
      r_d_rdata      <= '0;
    end else begin
      r_state  <= w_state_next;
      // Responses are single-cycle pulses unless set below.
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_last_grant <= w_grant;
            if (w_grant == GRANT_D) begin
              r_pmem_address <= d_address;
              r_pmem_wdata   <= d_wdata;
              r_pmem_write   <= d_write;
              r_pmem_read    <= ~d_write;
            end else begin
              // pmem_wdata keeps its previous value; memory ignores it
              // on reads.
              r_pmem_address <= i_address;
              r_pmem_write   <= 1'b0;
              r_pmem_read    <= 1'b1;
            end
          end
        end
        I_BUSY: begin
          if (pmem_resp) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_i_rdata    <= pmem_rdata;
            r_i_resp     <= 1'b1;
          end
        end
        D_BUSY: begin
          if (pmem_resp) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_d_rdata    <= pmem_rdata;
            r_d_resp     <= 1'b1;
          end
        end
        default: begin
          // DONE: no grant, nothing latched; pmem_resp is ignored here.
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;
  assign i_resp       = r_i_resp;
  assign i_rdata      = r_i_rdata;
  assign d_resp       = r_d_resp;
  assign d_rdata      = r_d_rdata;

endmodule : cache_arbiter
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_arbiter
// Description : Self-checking bench for cache_arbiter. Single-requester
//               transactions come from a vector table; contention, reset
//               mid-transaction and zero-latency memory are hand sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic          i_resp;
  logic [LW-1:0] i_rdata;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic          d_resp;
  logic [LW-1:0] d_rdata;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_resp       (i_resp),
    .i_rdata      (i_rdata),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_resp       (d_resp),
    .d_rdata      (d_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state kept by the bench.
  logic [LW-1:0] m_wdata;
  logic [LW-1:0] m_i;
  logic [LW-1:0] m_d;
  bit            d_known;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit            is_d;
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    int            lat;
    logic [LW-1:0] mdata;
    bit            exp_wr;
  } vec_t;

  vec_t vecs[5];

  // One complete single-requester transaction, checked cycle by cycle.
  // Inputs are driven and outputs sampled on the falling edge.
  task automatic do_txn(input vec_t v);
    @(negedge clk);
    if (v.is_d) begin
      d_read = v.rd; d_write = v.wr; d_address = v.addr; d_wdata = v.wdata;
      m_wdata = v.wdata;
    end else begin
      i_read = 1'b1; i_address = v.addr;
    end
    @(negedge clk);
    chk("cmd_read",  pmem_read,  !v.exp_wr);
    chk("cmd_write", pmem_write, v.exp_wr);
    chk("cmd_addr",  pmem_address, v.addr);
    chk("cmd_wdata", pmem_wdata, m_wdata);
    for (int k = 1; k < v.lat; k++) begin
      // Scramble held inputs: the latched command must not follow them.
      d_wdata   = ~v.wdata;
      d_address = v.addr ^ 32'hFFFF_0000;
      i_address = v.addr ^ 32'h0F0F_0000;
      @(negedge clk);
      chk("hold_addr",  pmem_address, v.addr);
      chk("hold_wdata", pmem_wdata, m_wdata);
      chk("hold_cmd",   pmem_read | pmem_write, 1'b1);
    end
    pmem_resp = 1'b1; pmem_rdata = v.mdata;
    @(negedge clk);
    pmem_resp = 1'b0; pmem_rdata = '1;
    if (v.is_d) begin
      m_d = v.mdata; d_known = !v.exp_wr;
    end else begin
      m_i = v.mdata;
    end
    chk("resp_i",   i_resp, !v.is_d);
    chk("resp_d",   d_resp, v.is_d);
    chk("resp_cmd", pmem_read | pmem_write, 1'b0);
    chk("i_rdata",  i_rdata, m_i);
    if (d_known) chk("d_rdata", d_rdata, m_d);
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    d_wdata = '0; d_address = '0; i_address = '0;
    @(negedge clk);
    chk("done_resp", i_resp | d_resp, 1'b0);
    chk("done_cmd",  pmem_read | pmem_write, 1'b0);
    @(negedge clk);
    chk("idle_cmd",  pmem_read | pmem_write, 1'b0);
  endtask

  initial begin
    logic [LW-1:0] r1, r2, r3, r4;
    int  nr_i, nr_d;
    bit  prev, overlap, back2back;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, '0,               4, {32{8'hA5}}, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, {8{32'h1234_5678}}, 3, {32{8'h77}}, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0200, {8{32'hDEAD_BEEF}}, 2, {32{8'h5A}}, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0300, {32{8'hC3}},        1, {32{8'h99}}, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0080, '0,               1, {32{8'h0F}}, 1'b0};

    r1 = {8{32'h1111_2222}};
    r2 = {8{32'h3333_4444}};
    r3 = {8{32'h5555_6666}};
    r4 = {8{32'h7777_8888}};

    reset = 1'b1;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    m_wdata = '0; m_i = '0; m_d = '0; d_known = 1'b1;

    // ---- reset state ----
    @(negedge clk); @(negedge clk);
    chk("rst_cmd",   {pmem_read, pmem_write, i_resp, d_resp}, 4'b0);
    chk("rst_addr",  pmem_address, 32'h0);
    chk("rst_wdata", pmem_wdata, '0);
    chk("rst_rdata", i_rdata | d_rdata, '0);
    reset = 1'b0;

    // ---- contention straight after reset: D first, then I, then D again ----
    @(negedge clk);
    i_read = 1'b1; i_address = 32'h0000_1000;
    d_read = 1'b1; d_address = 32'h0000_2000;
    @(negedge clk);
    chk("c1_read", pmem_read, 1'b1);
    chk("c1_addr", pmem_address, 32'h0000_2000);
    pmem_resp = 1'b1; pmem_rdata = r1;
    @(negedge clk);
    pmem_resp = 1'b0; m_d = r1;
    chk("c1_dresp", {d_resp, i_resp}, 2'b10);
    chk("c1_drdata", d_rdata, r1);
    chk("c1_cmd_off", pmem_read, 1'b0);
    d_read = 1'b0;
    @(negedge clk);
    chk("c1_done_gap", pmem_read, 1'b0);
    @(negedge clk);
    chk("c2_read", pmem_read, 1'b1);
    chk("c2_addr", pmem_address, 32'h0000_1000);
    pmem_resp = 1'b1; pmem_rdata = r2;
    @(negedge clk);
    pmem_resp = 1'b0; m_i = r2;
    chk("c2_iresp", {d_resp, i_resp}, 2'b01);
    chk("c2_irdata", i_rdata, r2);
    chk("c2_dhold", d_rdata, r1);
    i_read = 1'b0;
    @(negedge clk);
    i_read = 1'b1; i_address = 32'h0000_1040;
    d_read = 1'b1; d_address = 32'h0000_2040;
    @(negedge clk);
    chk("c3_addr", pmem_address, 32'h0000_2040);
    pmem_resp = 1'b1; pmem_rdata = r3;
    @(negedge clk);
    pmem_resp = 1'b0; m_d = r3;
    chk("c3_dresp", {d_resp, i_resp}, 2'b10);
    d_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("c4_addr", pmem_address, 32'h0000_1040);
    pmem_resp = 1'b1; pmem_rdata = r4;
    @(negedge clk);
    pmem_resp = 1'b0; m_i = r4;
    chk("c4_iresp", {d_resp, i_resp}, 2'b01);
    chk("c4_irdata", i_rdata, r4);
    i_read = 1'b0; i_address = '0; d_address = '0;
    @(negedge clk);
    @(negedge clk);

    // ---- table-driven single-requester transactions ----
    for (int v = 0; v < 5; v++) do_txn(vecs[v]);

    // ---- reset asserted mid-transaction ----
    @(negedge clk);
    d_write = 1'b1; d_address = 32'h0000_0400; d_wdata = {8{32'hFACE_0001}};
    @(negedge clk);
    chk("mr_write", pmem_write, 1'b1);
    #2 reset = 1'b1;
    #1 chk("mr_async_clr", {pmem_write, pmem_read}, 2'b00);
    chk("mr_async_addr", pmem_address, 32'h0);
    @(negedge clk);
    d_write = 1'b0; d_address = '0; d_wdata = '0;
    reset = 1'b0;
    m_i = '0; m_d = '0; m_wdata = '0; d_known = 1'b1;
    pmem_resp = 1'b1; pmem_rdata = r1;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("mr_no_resp", {i_resp, d_resp}, 2'b00);
    @(negedge clk);
    chk("mr_no_resp2", {i_resp, d_resp, pmem_read, pmem_write}, 4'b0);
    chk("mr_rdata", d_rdata, '0);

    // ---- zero-latency memory, both caches requesting continuously ----
    pmem_resp = 1'b1; pmem_rdata = r2;
    i_read = 1'b1; d_read = 1'b1;
    nr_i = 0; nr_d = 0; prev = 1'b0; overlap = 1'b0; back2back = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (i_resp && d_resp) overlap = 1'b1;
      if (prev && (i_resp || d_resp)) back2back = 1'b1;
      prev = i_resp || d_resp;
      if (i_resp) nr_i++;
      if (d_resp) nr_d++;
    end
    chk("zl_i_count", nr_i, 2);
    chk("zl_d_count", nr_d, 2);
    chk("zl_overlap", overlap, 1'b0);
    chk("zl_back2back", back2back, 1'b0);
    i_read = 1'b0; d_read = 1'b0; pmem_resp = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cache_arbiter
`default_nettype wire
